// File: rtl/fetch_unit.sv
// PC / IR stage of the multicycle DLX core: holds PC, latches the fetched
// word, applies controller PC-update strobes and decodes register fields.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_I,
  input  logic        enable_PC,
  input  logic        sel_inc,
  input  logic        load_new_PC,
  input  logic        link,
  input  logic [31:0] reg_a,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  dest_reg,
  output logic [31:0] imm_sext,
  output logic [31:0] link_data,
  output logic        misalign_err
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_JALR  = 6'h13;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        mis_q, mis_d;
  logic [31:0] off_j, off_b, target;
  logic        is_jump;

  // link only qualifies the write-back; the return address is simply PC
  logic unused_link;
  assign unused_link = link;

  assign is_jump = (ir_q[31:26] == OP_J) || (ir_q[31:26] == OP_JAL);
  assign off_j   = {{4{ir_q[25]}}, ir_q[25:0], 2'b00};
  assign off_b   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign target  = load_new_PC ? reg_a : (pc_q + (is_jump ? off_j : off_b));

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mis_d = mis_q;
    if (enable_I) ir_d = imem_rdata;
    if (enable_PC) begin
      if (sel_inc) begin
        pc_d = pc_q + 32'd4;
      end else begin
        // force alignment of the redirect but remember that it happened
        pc_d = target & ~32'h3;
        if (target[1:0] != 2'b00) mis_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= 32'h0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mis_q <= mis_d;
    end
  end

  always_comb begin
    dest_reg = ir_q[20:16];
    if (ir_q[31:26] == OP_JAL || ir_q[31:26] == OP_JALR) dest_reg = LINK_REG;
    else if (ir_q[31:26] == OP_RTYPE)                    dest_reg = ir_q[15:11];
  end

  assign imem_addr    = pc_q;
  assign link_data    = pc_q;
  assign opcode       = ir_q[31:26];
  assign rs1          = ir_q[25:21];
  assign rs2          = ir_q[20:16];
  assign imm_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus reset/wrap sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n, enable_I, enable_PC, sel_inc, load_new_PC, link;
  logic [31:0] reg_a, imem_rdata, imem_addr, imm_sext, link_data;
  logic [5:0]  opcode;
  logic [4:0]  rs1, rs2, dest_reg;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .enable_I(enable_I), .enable_PC(enable_PC),
    .sel_inc(sel_inc), .load_new_PC(load_new_PC), .link(link), .reg_a(reg_a),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .opcode(opcode), .rs1(rs1),
    .rs2(rs2), .dest_reg(dest_reg), .imm_sext(imm_sext), .link_data(link_data),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en_i, en_pc, inc, lnp, lnk;
    logic [31:0] reg_a, rdata;
    logic [31:0] exp_pc, exp_ir;
    logic [5:0]  exp_op;
    logic [4:0]  exp_dest;
    logic [31:0] exp_imm;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ei, epc, inc, lnp, lnk, input logic [31:0] ra, rd);
    enable_I = ei; enable_PC = epc; sel_inc = inc; load_new_PC = lnp; link = lnk;
    reg_a = ra; imem_rdata = rd;
  endtask

  initial begin
    //             en_i en_pc inc lnp lnk reg_a          rdata          pc             ir             op     dest   imm            mis
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h2001_0005, 32'h4,         32'h2001_0005, 6'h08, 5'd1,  32'h5,         1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h2001_0005, 32'h8,         32'h2001_0005, 6'h08, 5'd1,  32'h5,         1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h2001_0005, 32'hC,         32'h2001_0005, 6'h08, 5'd1,  32'h5,         1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h100,      32'h0,         32'h100,       32'h2001_0005, 6'h08, 5'd1,  32'h5,         1'b0};
    vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h1000_FFFE, 32'h104,       32'h1000_FFFE, 6'h04, 5'd0,  32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,         32'hFC,        32'h1000_FFFE, 6'h04, 5'd0,  32'hFFFF_FFFE, 1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h200,      32'h0,         32'h200,       32'h1000_FFFE, 6'h04, 5'd0,  32'hFFFF_FFFE, 1'b0};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0C00_0010, 32'h204,       32'h0C00_0010, 6'h03, 5'd31, 32'h10,        1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0,         32'h204,       32'h0C00_0010, 6'h03, 5'd31, 32'h10,        1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,         32'h244,       32'h0C00_0010, 6'h03, 5'd31, 32'h10,        1'b0};
    vecs[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h4C22_0000, 32'h248,       32'h4C22_0000, 6'h13, 5'd31, 32'h0,         1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h1000,     32'h0,         32'h1000,      32'h4C22_0000, 6'h13, 5'd31, 32'h0,         1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h3000,     32'h0,         32'h1000,      32'h4C22_0000, 6'h13, 5'd31, 32'h0,         1'b0};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h2002,     32'h0,         32'h2000,      32'h4C22_0000, 6'h13, 5'd31, 32'h0,         1'b1};
    vecs[14] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0000_1820, 32'h2004,      32'h0000_1820, 6'h00, 5'd3,  32'h1820,      1'b1};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b1,1'b0,32'h5555,     32'h0,         32'h2008,      32'h0000_1820, 6'h00, 5'd3,  32'h1820,      1'b1};

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    #12;
    chk("rst_pc",   imem_addr, 32'h0);
    chk("rst_op",   {26'h0, opcode}, 32'h0);
    chk("rst_dest", {27'h0, dest_reg}, 32'h0);
    chk("rst_imm",  imm_sext, 32'h0);
    chk("rst_link", link_data, 32'h0);
    chk("rst_mis",  {31'h0, misalign_err}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en_i, vecs[i].en_pc, vecs[i].inc, vecs[i].lnp, vecs[i].lnk,
            vecs[i].reg_a, vecs[i].rdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i),   imem_addr, vecs[i].exp_pc);
      chk($sformatf("v%0d_link", i), link_data, vecs[i].exp_pc);
      chk($sformatf("v%0d_ir", i),   {opcode, rs1, rs2, imm_sext[15:0]}, vecs[i].exp_ir);
      chk($sformatf("v%0d_op", i),   {26'h0, opcode}, {26'h0, vecs[i].exp_op});
      chk($sformatf("v%0d_dest", i), {27'h0, dest_reg}, {27'h0, vecs[i].exp_dest});
      chk($sformatf("v%0d_imm", i),  imm_sext, vecs[i].exp_imm);
      chk($sformatf("v%0d_mis", i),  {31'h0, misalign_err}, {31'h0, vecs[i].exp_mis});
    end

    // sticky error clears only on reset
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    reset_n = 1'b0; #1;
    chk("clr_mis", {31'h0, misalign_err}, 32'h0);
    chk("clr_pc",  imem_addr, 32'h0);
    reset_n = 1'b1;

    // wrap at top of address space
    drive(0, 1, 0, 1, 0, 32'hFFFF_FFFC, 32'h0);
    @(posedge clk); #1;
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    drive(0, 1, 1, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("wrap_zero", imem_addr, 32'h0);
    chk("wrap_mis",  {31'h0, misalign_err}, 32'h0);

    // async reset between edges, with an update pending
    drive(1, 1, 1, 0, 0, 32'h0, 32'h2001_0005);
    @(posedge clk); #1;
    chk("pre_pc", imem_addr, 32'h4);
    chk("pre_op", {26'h0, opcode}, 32'h8);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pc",   imem_addr, 32'h0);
    chk("async_ir",   {opcode, rs1, rs2, imm_sext[15:0]}, 32'h0);
    chk("async_link", link_data, 32'h0);
    @(posedge clk); #1;
    chk("held_pc", imem_addr, 32'h0);
    chk("held_ir", {opcode, rs1, rs2, imm_sext[15:0]}, 32'h0);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
